// File: rtl/farrow_pp_interp_mc.sv
// Multi-channel Farrow piecewise-parabolic / linear interpolator with valid/ready backpressure.
// Four-tap line per channel; each strobe yields one rounded, saturated interpolant three beats later.
module farrow_pp_interp_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int MU_WIDTH   = 10,
    parameter int ALPHA_Q15  = 16384
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           mode,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
    input  logic                           s_strobe,
    input  logic [MU_WIDTH-1:0]            s_mu,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   m_data,
    output logic [NUM_CH-1:0]              m_sat,
    output logic                           warm
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned LW = NUM_CH * DATA_WIDTH;
    localparam int unsigned SC = 2 * MU_WIDTH + 15;
    localparam int unsigned VW = DATA_WIDTH + 20;
    localparam int unsigned AW = VW + 2 * MU_WIDTH + 4;

    localparam logic signed [VW-1:0] ALPHA   = VW'(ALPHA_Q15);
    localparam logic signed [VW-1:0] ONE_P_A = VW'(32768 + ALPHA_Q15);
    localparam logic signed [VW-1:0] ONE_M_A = VW'(32768 - ALPHA_Q15);
    localparam logic signed [AW-1:0] HALF    = AW'(1) <<< (SC - 1);
    localparam logic signed [AW-1:0] Y_MAX   = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] Y_MIN   = -(AW'(1) <<< (DW - 1));

    logic              en;
    logic              accept;
    logic [2:0]        count;
    logic [2:0]        count_nx;
    logic [LW-1:0]     d0, d1, d2, d3;

    // Snapshot of post-shift taps for a strobe, so a later flush cannot disturb it
    logic              p_valid;
    logic [LW-1:0]     p_d0, p_d1, p_d2, p_d3;
    logic [MU_WIDTH-1:0] p_mu;
    logic              p_mode;

    logic              s1_valid;
    logic [MU_WIDTH-1:0] s1_mu;
    logic signed [VW-1:0] s1_v0 [NUM_CH];
    logic signed [VW-1:0] s1_v1 [NUM_CH];
    logic signed [VW-1:0] s1_v2 [NUM_CH];
    logic signed [VW-1:0] v0_c  [NUM_CH];
    logic signed [VW-1:0] v1_c  [NUM_CH];
    logic signed [VW-1:0] v2_c  [NUM_CH];
    logic signed [VW-1:0] e0, e1, e2, e3;

    logic              s2_valid;
    logic signed [AW-1:0] s2_sum [NUM_CH];
    logic signed [AW-1:0] sum_c  [NUM_CH];
    logic signed [AW-1:0] mu_s;
    logic signed [AW-1:0] rnd_c  [NUM_CH];

    logic [LW-1:0]     y_c;
    logic [NUM_CH-1:0] sat_c;

    assign en       = !(m_valid && !m_ready);
    assign s_ready  = !rst && en;
    assign accept   = s_valid && s_ready;
    assign count_nx = (count == 3'd4) ? 3'd4 : count + 3'd1;

    // Delay line and fill count
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            count <= 3'd0;
            warm  <= 1'b0;
        end else if (accept) begin
            d0    <= s_data;
            d1    <= d0;
            d2    <= d1;
            d3    <= d2;
            count <= count_nx;
            warm  <= (count_nx == 3'd4);
        end
    end

    // Strobe capture: only a full line outside a flush cycle issues an output
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_d0    <= '0;
            p_d1    <= '0;
            p_d2    <= '0;
            p_d3    <= '0;
            p_mu    <= '0;
            p_mode  <= 1'b0;
        end else if (en) begin
            p_valid <= accept && !flush && s_strobe && (count_nx == 3'd4);
            if (accept && s_strobe) begin
                p_d0   <= s_data;
                p_d1   <= d0;
                p_d2   <= d1;
                p_d3   <= d2;
                p_mu   <= s_mu;
                p_mode <= mode;
            end
        end
    end

    // S1: Farrow coefficients in Q15; linear mode folds into v1 with v2 = 0
    always_comb begin
        v0_c = '{default: '0};
        v1_c = '{default: '0};
        v2_c = '{default: '0};
        e0   = '0;
        e1   = '0;
        e2   = '0;
        e3   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e0 = VW'($signed(p_d0[c*DW +: DW]));
            e1 = VW'($signed(p_d1[c*DW +: DW]));
            e2 = VW'($signed(p_d2[c*DW +: DW]));
            e3 = VW'($signed(p_d3[c*DW +: DW]));
            v0_c[c] = e2;
            if (p_mode) begin
                v2_c[c] = ALPHA * (e0 - e1 - e2 + e3);
                v1_c[c] = ONE_P_A * e1 - ALPHA * e0 - ONE_M_A * e2 - ALPHA * e3;
            end else begin
                v1_c[c] = (e1 - e2) <<< 15;
            end
        end
    end

    // S2: everything aligned to scale 2^SC before summing
    always_comb begin
        mu_s  = AW'($signed({1'b0, s1_mu}));
        sum_c = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            sum_c[c] = AW'(s1_v2[c]) * mu_s * mu_s
                     + ((AW'(s1_v1[c]) * mu_s) <<< MU_WIDTH)
                     + (AW'(s1_v0[c]) <<< SC);
        end
    end

    // S3: round half up, then clip to the sample range
    always_comb begin
        y_c   = '0;
        sat_c = '0;
        rnd_c = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            rnd_c[c] = (s2_sum[c] + HALF) >>> SC;
            if (rnd_c[c] > Y_MAX) begin
                y_c[c*DW +: DW] = DW'(Y_MAX);
                sat_c[c]        = 1'b1;
            end else if (rnd_c[c] < Y_MIN) begin
                y_c[c*DW +: DW] = DW'(Y_MIN);
                sat_c[c]        = 1'b1;
            end else begin
                y_c[c*DW +: DW] = DW'(rnd_c[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mu    <= '0;
            s1_v0    <= '{default: '0};
            s1_v1    <= '{default: '0};
            s1_v2    <= '{default: '0};
            s2_valid <= 1'b0;
            s2_sum   <= '{default: '0};
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sat    <= '0;
        end else if (en) begin
            s1_valid <= p_valid;
            s1_mu    <= p_mu;
            s1_v0    <= v0_c;
            s1_v1    <= v1_c;
            s1_v2    <= v2_c;
            s2_valid <= s1_valid;
            s2_sum   <= sum_c;
            m_valid  <= s2_valid;
            if (s2_valid) begin
                m_data <= y_c;
                m_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_farrow_pp_interp_mc.sv
// Directed bench for farrow_pp_interp_mc: fixed vectors with hand-computed interpolants.
module tb_farrow_pp_interp_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mode;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_strobe;
    logic [9:0]  s_mu;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  m_sat;
    logic        warm;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    farrow_pp_interp_mc #(
        .DATA_WIDTH(16), .NUM_CH(2), .MU_WIDTH(10), .ALPHA_Q15(16384)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_strobe(s_strobe), .s_mu(s_mu),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sat(m_sat), .warm(warm)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input int exp);
        logic signed [63:0] e;
        e = 64'(exp);
        n_checks++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b, input logic stb, input int mu, input logic md);
        s_valid  = 1'b1;
        s_data   = {16'(b), 16'(a)};
        s_strobe = stb;
        s_mu     = 10'(mu);
        mode     = md;
        step();
        s_valid  = 1'b0;
        s_strobe = 1'b0;
    endtask

    task automatic feed4(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int mu, input logic md);
        beat(a0, b0, 1'b0, 0, 1'b0);
        beat(a1, b1, 1'b0, 0, 1'b0);
        beat(a2, b2, 1'b0, 0, 1'b0);
        beat(a3, b3, 1'b1, mu, md);
    endtask

    task automatic expect_out(input string tag, input int y0, input int y1, input int sat);
        step();
        step();
        step();
        chk({tag, "_valid"}, 64'(m_valid), 1);
        chk({tag, "_ch0"}, 64'($signed(m_data[15:0])), y0);
        chk({tag, "_ch1"}, 64'($signed(m_data[31:16])), y1);
        chk({tag, "_sat"}, 64'(m_sat), sat);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int seen;
        int exp_q [4];
        logic signed [15:0] got [$];

        rst = 1'b1; flush = 1'b0; mode = 1'b0; s_valid = 1'b0;
        s_data = '0; s_strobe = 1'b0; s_mu = '0; m_ready = 1'b1;
        step();
        step();
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_m_data", 64'(m_data), 0);
        chk("rst_m_sat", 64'(m_sat), 0);
        chk("rst_warm", 64'(warm), 0);
        chk("rst_s_ready", 64'(s_ready), 0);
        rst = 1'b0;
        step();
        chk("s_ready_up", 64'(s_ready), 1);

        // Ramp, mu=0, exact latency of three edges
        beat(0, 0, 1'b0, 0, 1'b1);
        beat(100, 0, 1'b0, 0, 1'b1);
        beat(200, 0, 1'b0, 0, 1'b1);
        chk("t1_warm3", 64'(warm), 0);
        beat(300, 0, 1'b1, 0, 1'b1);
        chk("t1_warm4", 64'(warm), 1);
        chk("t1_lat0", 64'(m_valid), 0);
        step();
        chk("t1_lat1", 64'(m_valid), 0);
        step();
        chk("t1_lat2", 64'(m_valid), 0);
        step();
        chk("t1_lat3", 64'(m_valid), 1);
        chk("t1_ch0", 64'($signed(m_data[15:0])), 100);
        step();
        chk("t1_single", 64'(m_valid), 0);

        // Ramp at mu=0.5 both modes; constant ch1 passes through
        feed4(0, 100, 200, 300, 77, 77, 77, 77, 512, 1'b1);
        expect_out("t2_para", 150, 77, 0);
        feed4(0, 100, 200, 300, 77, 77, 77, 77, 512, 1'b0);
        expect_out("t2_lin", 150, 77, 0);
        feed4(0, 100, 200, 300, 0, 0, 0, 0, 1023, 1'b0);
        expect_out("t2_mu_max", 200, 0, 0);

        // Impulse: parabolic curvature vs linear
        feed4(0, 0, 1000, 0, 0, 0, 0, 0, 512, 1'b1);
        expect_out("t3_para", 625, 0, 0);
        feed4(0, 0, 1000, 0, 0, 0, -1000, 0, 512, 1'b0);
        expect_out("t3_lin", 500, -500, 0);
        // Exact halves round upward: +0.5 -> 1, -0.5 -> 0
        feed4(0, 0, 1, 0, 0, 0, -1, 0, 512, 1'b0);
        expect_out("t3_half", 1, 0, 0);

        // Saturation at both rails, flagged per channel
        feed4(-32768, 32767, 32767, -32768, 0, 0, 0, 0, 512, 1'b1);
        expect_out("t4_pos", 32767, 0, 1);
        feed4(0, 0, 0, 0, 32767, -32768, -32768, 32767, 512, 1'b1);
        expect_out("t4_neg", 0, -32768, 2);

        // Four back-to-back strobes then a five-cycle stall
        beat(10, 0, 1'b0, 0, 1'b0);
        beat(20, 0, 1'b0, 0, 1'b0);
        beat(30, 0, 1'b0, 0, 1'b0);
        beat(40, 0, 1'b0, 0, 1'b0);
        beat(50, 0, 1'b1, 512, 1'b0);
        beat(60, 0, 1'b1, 512, 1'b0);
        beat(70, 0, 1'b1, 512, 1'b0);
        beat(80, 0, 1'b1, 512, 1'b0);
        m_ready = 1'b0;
        chk("t5_first_valid", 64'(m_valid), 1);
        chk("t5_first_data", 64'($signed(m_data[15:0])), 35);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_stall_valid", 64'(m_valid), 1);
            chk("t5_stall_data", 64'($signed(m_data[15:0])), 35);
            chk("t5_stall_ready", 64'(s_ready), 0);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) got.push_back($signed(m_data[15:0]));
            step();
        end
        exp_q = '{35, 45, 55, 65};
        chk("t5_count", 64'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", (i < got.size()) ? 64'(got[i]) : 64'hx, exp_q[i]);
        end

        // Warm-up, flush and reset behaviour
        rst = 1'b1;
        step();
        rst = 1'b0;
        beat(1, 0, 1'b0, 0, 1'b1);
        beat(2, 0, 1'b0, 0, 1'b1);
        beat(3, 0, 1'b1, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid) seen++;
            step();
        end
        chk("t6_cold_drop", 64'(seen), 0);

        flush = 1'b1;
        beat(9999, 0, 1'b1, 0, 1'b1);
        flush = 1'b0;
        chk("t6_flush_warm", 64'(warm), 0);
        beat(1000, 7, 1'b0, 0, 1'b1);
        beat(2000, 7, 1'b0, 0, 1'b1);
        beat(3000, 7, 1'b1, 0, 1'b1);
        chk("t6_third_warm", 64'(warm), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid) seen++;
            step();
        end
        chk("t6_flush_drop", 64'(seen), 0);
        beat(4000, 7, 1'b1, 0, 1'b1);
        chk("t6_fourth_warm", 64'(warm), 1);
        expect_out("t6_fourth", 2000, 7, 0);

        beat(5000, 7, 1'b1, 0, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_valid", 64'(m_valid), 0);
        chk("t6_rst_ready", 64'(s_ready), 0);
        chk("t6_rst_warm", 64'(warm), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid) seen++;
            step();
        end
        chk("t6_rst_stale", 64'(seen), 0);
        chk("t6_rst_data", 64'(m_data), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
